// File: rtl/sram_like_memory_responder_pkg.sv
// Shared types and helpers for the sram-like memory responder: access sizes,
// the captured request bundle, response FIFO entries and the strobe legality rule.
package sram_like_params;

   localparam int CYCLE_BITS = 5;

   typedef logic [CYCLE_BITS-1:0] cycle_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_t;

   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic [31:0] address;
      logic [31:0] write_data;
      logic [3:0]  write_strobe;
   } request_t;

   typedef struct packed {
      logic [31:0] data;
      cycle_t      release_cycle;
   } response_entry_t;

   // A store's strobe must cover exactly the lanes its size and low address select.
   function automatic logic strobe_legal(input logic [1:0] size, input logic [1:0] addr_lo,
                                         input logic [3:0] strobe);
      logic legal;
      case (size)
         SIZE_BYTE: legal = (strobe == (4'b0001 << addr_lo));
         SIZE_HALF: legal = addr_lo[1] ? (strobe == 4'b1100) : (strobe == 4'b0011);
         SIZE_WORD: legal = (strobe == 4'b1111);
         default:   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/sram_like_memory_responder_if.sv
// Sram-like request/response bus between the core (master) and the memory responder (slave).
interface sram_like_if;
   import sram_like_params::*;

   logic        request;
   logic        write;
   logic [1:0]  size;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic        address_ready;
   logic [31:0] read_data;
   logic        data_ready;
   logic        protocol_error;

   modport master (
      output request, write, size, address, write_data, write_strobe,
      input  address_ready, read_data, data_ready, protocol_error
   );

   modport slave (
      input  request, write, size, address, write_data, write_strobe,
      output address_ready, read_data, data_ready, protocol_error
   );

endinterface

// File: rtl/sram_like_memory_responder_fifo.sv
// Circular FIFO of pending responses; head is visible combinationally so the
// responder can test its release time before popping.
module sram_like_response_fifo
   import sram_like_params::*;
#(
   parameter int   ENTRIES  = 4,
   localparam int  IDX_BITS = $clog2(ENTRIES)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            push,
   input  response_entry_t push_entry,
   input  logic            pop,
   output response_entry_t head,
   output logic            full,
   output logic            empty,
   output logic [IDX_BITS:0] count
);

   localparam logic [IDX_BITS:0] PTR_ONE = 1;

   response_entry_t   entries_reg [ENTRIES];
   logic [IDX_BITS:0] wr_ptr_reg;
   logic [IDX_BITS:0] rd_ptr_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop && !empty) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push && !full) begin
         entries_reg[wr_ptr_reg[IDX_BITS-1:0]] <= push_entry;
      end
   end

   // Extra pointer bit separates the full and empty cases when indices match.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[IDX_BITS] != rd_ptr_reg[IDX_BITS]) &&
                  (wr_ptr_reg[IDX_BITS-1:0] == rd_ptr_reg[IDX_BITS-1:0]);
   assign count = wr_ptr_reg - rd_ptr_reg;
   assign head  = entries_reg[rd_ptr_reg[IDX_BITS-1:0]];

endmodule

// File: rtl/sram_like_memory_responder.sv
// On-chip word RAM behind the sram-like bus: accepts up to MAX_OUTSTANDING
// transactions and answers them in order no earlier than LATENCY cycles later.
module sram_like_memory_responder
   import sram_like_params::*;
#(
   parameter int DEPTH           = 4096,
   parameter int LATENCY         = 1,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clock,
   input  logic        reset,
   sram_like_if.slave  bus
);

   localparam int     WORD_BITS = $clog2(DEPTH);
   localparam int     OCC_BITS  = $clog2(MAX_OUTSTANDING) + 1;
   localparam cycle_t LATENCY_C = cycle_t'(LATENCY);
   localparam cycle_t CYCLE_ONE = cycle_t'(1);

   request_t              req;
   logic                  reset_q_reg;
   cycle_t                cycle_count_reg;
   logic                  accept;
   logic                  illegal;
   logic                  store_en;
   logic [WORD_BITS-1:0]  word_index;
   logic [31:0]           read_word;

   logic                  stage_valid_reg;
   logic                  stage_load_reg;
   cycle_t                stage_release_reg;
   response_entry_t       stage_entry;

   response_entry_t       fifo_head;
   response_entry_t       head_entry;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [OCC_BITS-1:0]   fifo_count;
   logic [OCC_BITS-1:0]   occupancy;
   logic                  head_valid;
   cycle_t                head_age;
   logic                  pop;
   logic                  fifo_pop;
   logic                  fifo_push;

   logic                  data_ready_reg;
   logic [31:0]           read_data_reg;
   logic                  error_reg;
   logic                  unused_bits;

   assign req = '{write:        bus.write,
                  size:         bus.size,
                  address:      bus.address,
                  write_data:   bus.write_data,
                  write_strobe: bus.write_strobe};

   // The load in the stage register still owns a slot until it moves on.
   assign occupancy         = fifo_count + OCC_BITS'(stage_valid_reg);
   assign bus.address_ready = ~reset & ~reset_q_reg &
                              (occupancy < OCC_BITS'(MAX_OUTSTANDING));
   assign accept            = bus.request & bus.address_ready;
   assign word_index        = req.address[WORD_BITS+1:2];

   always_comb begin
      illegal = 1'b0;
      case (req.size)
         SIZE_BYTE: illegal = 1'b0;
         SIZE_HALF: illegal = req.address[0];
         SIZE_WORD: illegal = |req.address[1:0];
         default:   illegal = 1'b1;
      endcase
      if (req.write && !strobe_legal(req.size, req.address[1:0], req.write_strobe)) begin
         illegal = 1'b1;
      end
   end

   assign store_en = accept & req.write & ~illegal;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] lane_read_reg;

         always_ff @(posedge clock) begin
            if (store_en && req.write_strobe[gi]) begin
               lane_mem[word_index] <= req.write_data[8*gi +: 8];
            end
            if (accept) begin
               lane_read_reg <= lane_mem[word_index];
            end
         end

         assign read_word[8*gi +: 8] = lane_read_reg;
      end
   endgenerate

   // One-cycle stage covers the RAM read latency; it drains every cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         stage_valid_reg   <= 1'b0;
         stage_load_reg    <= 1'b0;
         stage_release_reg <= '0;
      end else begin
         stage_valid_reg   <= accept;
         stage_load_reg    <= ~req.write;
         stage_release_reg <= cycle_count_reg + LATENCY_C;
      end
   end

   assign stage_entry = '{data:          stage_load_reg ? read_word : 32'h0,
                          release_cycle: stage_release_reg};

   assign head_entry = fifo_empty ? stage_entry : fifo_head;
   assign head_valid = ~fifo_empty | stage_valid_reg;
   assign head_age   = cycle_count_reg - head_entry.release_cycle;
   assign pop        = head_valid & ~head_age[CYCLE_BITS-1];
   assign fifo_pop   = pop & ~fifo_empty;
   assign fifo_push  = stage_valid_reg & ~(pop & fifo_empty);

   sram_like_response_fifo #(
      .ENTRIES (MAX_OUTSTANDING)
   ) u_response_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (fifo_push),
      .push_entry (stage_entry),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   always_ff @(posedge clock) begin
      reset_q_reg <= reset;
      if (reset) begin
         cycle_count_reg <= '0;
         data_ready_reg  <= 1'b0;
         read_data_reg   <= '0;
         error_reg       <= 1'b0;
      end else begin
         cycle_count_reg <= cycle_count_reg + CYCLE_ONE;
         data_ready_reg  <= pop;
         if (pop) begin
            read_data_reg <= head_entry.data;
         end
         if (accept && illegal) begin
            error_reg <= 1'b1;
         end
      end
   end

   assign bus.data_ready     = data_ready_reg;
   assign bus.read_data      = read_data_reg;
   assign bus.protocol_error = error_reg;

   assign unused_bits = &{1'b0, req.address[31:WORD_BITS+2], fifo_full};

endmodule

// File: tb/tb_sram_like_memory_responder.sv
// Bench for the sram-like responder: behavioural reference model checked every cycle
// on a LATENCY=3 instance, plus a LATENCY=8 instance for the back-pressure scenario.
module tb_sram_like_memory_responder;

   localparam int LAT  = 3;
   localparam int MAXO = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic reset_l8 = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   sram_like_if bus_main ();
   sram_like_if bus_l8 ();

   sram_like_memory_responder #(.DEPTH(4096), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_main)
   );

   sram_like_memory_responder #(.DEPTH(64), .LATENCY(8), .MAX_OUTSTANDING(4)) dut_l8 (
      .clock (clock),
      .reset (reset_l8),
      .bus   (bus_l8)
   );

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   // Reference rules: a size covers a set of lanes; misalignment or a strobe that
   // differs from those lanes (for stores) makes the transaction illegal.
   function automatic bit illegal_txn(input bit w, input logic [1:0] sz, input logic [1:0] lo,
                                      input logic [3:0] st);
      logic [3:0] lanes;
      bit aligned;
      case (sz)
         2'd0: begin aligned = 1'b1; lanes = 4'b0001 << lo; end
         2'd1: begin aligned = (lo[0] == 1'b0); lanes = 4'b0011 << lo; end
         2'd2: begin aligned = (lo == 2'd0); lanes = 4'b1111; end
         default: return 1'b1;
      endcase
      if (!aligned) return 1'b1;
      return w && (st != lanes);
   endfunction

   typedef struct { int due; logic [31:0] data; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] mem_m [16];
   int          last_due = 0;
   bit          err_m = 1'b0;
   bit          p_reset = 1'b1, p_acc = 1'b0, p_write;
   logic [1:0]  p_size;
   logic [31:0] p_addr, p_wdata;
   logic [3:0]  p_strobe;
   bit          m_bad, exp_dr, exp_rdy;
   logic [31:0] m_data, exp_rd;
   int          m_due;

   // Model: each negedge applies what the preceding edge did, then checks outputs.
   always @(negedge clock) begin
      if (p_reset) begin
         exp_q.delete();
         err_m = 1'b0;
         last_due = cyc;
      end else if (p_acc) begin
         m_bad = illegal_txn(p_write, p_size, p_addr[1:0], p_strobe);
         m_data = 32'h0;
         if (m_bad) err_m = 1'b1;
         if (!p_write) begin
            m_data = mem_m[p_addr[5:2]];
         end else if (!m_bad) begin
            for (int b = 0; b < 4; b++)
               if (p_strobe[b]) mem_m[p_addr[5:2]][8*b +: 8] = p_wdata[8*b +: 8];
         end
         m_due = (cyc + LAT > last_due + 1) ? cyc + LAT : last_due + 1;
         last_due = m_due;
         exp_q.push_back('{m_due, m_data});
      end
      exp_dr = 1'b0;
      exp_rd = 32'h0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         exp_dr = 1'b1;
         exp_rd = exp_q[0].data;
         void'(exp_q.pop_front());
      end
      exp_rdy = !p_reset && (exp_q.size() < MAXO);
      check_eq("model_data_ready", bus_main.data_ready, exp_dr);
      if (exp_dr) check_eq("model_read_data", bus_main.read_data, exp_rd);
      check_eq("model_protocol_error", bus_main.protocol_error, err_m);
      if (!reset) check_eq("model_address_ready", bus_main.address_ready, exp_rdy);
      p_reset  = reset;
      p_acc    = !reset && exp_rdy && (bus_main.request === 1'b1);
      p_write  = bus_main.write;
      p_size   = bus_main.size;
      p_addr   = bus_main.address;
      p_wdata  = bus_main.write_data;
      p_strobe = bus_main.write_strobe;
   end

   int          pl_cyc[$];
   logic [31:0] pl_data[$];
   always @(negedge clock) begin
      if (bus_main.data_ready === 1'b1) begin
         pl_cyc.push_back(cyc);
         pl_data.push_back(bus_main.read_data);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_txn(input bit w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st, output int acc_edge);
      bus_main.request      = 1'b1;
      bus_main.write        = w;
      bus_main.size         = sz;
      bus_main.address      = a;
      bus_main.write_data   = wd;
      bus_main.write_strobe = st;
      acc_edge = -1;
      for (int n = 0; n < 50 && acc_edge < 0; n++) begin
         @(negedge clock);
         if (bus_main.address_ready === 1'b1) acc_edge = cyc + 1;
         step();
      end
      bus_main.request = 1'b0;
      if (acc_edge < 0) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: actual=no accept required=accept within 50 cycles");
      end
   endtask

   task automatic expect_pulse(input string name, input int at, input logic [31:0] d);
      int hit = -1;
      foreach (pl_cyc[i]) if (pl_cyc[i] == at) hit = i;
      check_eq({name, "_pulse"}, 32'(hit >= 0), 32'd1);
      if (hit >= 0) check_eq({name, "_data"}, pl_data[hit], d);
   endtask

   initial begin
      int a0, a1, a2, e3, late;
      logic [20:0] rdy_mask, dr_mask;
      logic [1:0]  sz;
      logic [3:0]  lanes;
      logic [31:0] addr;

      bus_main.request = 1'b0; bus_main.write = 1'b0; bus_main.size = 2'd2;
      bus_main.address = '0; bus_main.write_data = '0; bus_main.write_strobe = '0;
      bus_l8.request = 1'b0; bus_l8.write = 1'b1; bus_l8.size = 2'd2;
      bus_l8.address = '0; bus_l8.write_data = 32'h5A5A_0F0F; bus_l8.write_strobe = 4'hF;
      foreach (mem_m[i]) mem_m[i] = 32'h0;

      // Reset held for three edges, then released.
      repeat (2) step();
      @(negedge clock);
      check_eq("rst_address_ready", bus_main.address_ready, 0);
      check_eq("rst_read_data", bus_main.read_data, 0);
      step();
      reset = 1'b0;
      @(negedge clock);
      check_eq("release_ready_low", bus_main.address_ready, 0);
      check_eq("release_data_ready", bus_main.data_ready, 0);
      check_eq("release_error", bus_main.protocol_error, 0);
      step();
      @(negedge clock);
      check_eq("release_ready_high", bus_main.address_ready, 1);
      step();

      for (int i = 0; i < 16; i++) do_txn(1'b1, 2'd2, 32'(i * 4), $urandom, 4'hF, a0);

      // Store then load, back to back.
      do_txn(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 4'hF, a0);
      do_txn(1'b0, 2'd2, 32'h10, 32'h0, 4'h0, a1);
      repeat (6) step();
      check_eq("t2_back_to_back", a1, a0 + 1);
      expect_pulse("t2_store", a0 + LAT, 32'h0);
      expect_pulse("t2_load", a1 + LAT, 32'hDEAD_BEEF);

      // Byte merge into an existing word.
      do_txn(1'b1, 2'd2, 32'h20, 32'h1122_3344, 4'hF, a0);
      do_txn(1'b1, 2'd0, 32'h21, 32'h0000_AA00, 4'b0010, a0);
      do_txn(1'b0, 2'd2, 32'h20, 32'h0, 4'h0, a1);
      repeat (6) step();
      expect_pulse("t3_merge", a1 + LAT, 32'h1122_AA44);

      // Misaligned word load and a bad-strobe half store.
      @(negedge clock);
      check_eq("t5_error_before", bus_main.protocol_error, 0);
      step();
      do_txn(1'b0, 2'd2, 32'h13, 32'h0, 4'h0, a0);
      @(negedge clock);
      check_eq("t5_error_set", bus_main.protocol_error, 1);
      step();
      repeat (5) step();
      expect_pulse("t5_illegal_resp", a0 + LAT, 32'hDEAD_BEEF);
      do_txn(1'b1, 2'd1, 32'h20, 32'hFFFF_FFFF, 4'hF, a0);
      do_txn(1'b0, 2'd2, 32'h20, 32'h0, 4'h0, a1);
      repeat (6) step();
      expect_pulse("t5_bad_store_ignored", a1 + LAT, 32'h1122_AA44);
      @(negedge clock);
      check_eq("t5_error_sticky", bus_main.protocol_error, 1);
      step();

      // Reset with three loads in flight, long idle, then latency again.
      do_txn(1'b0, 2'd2, 32'h10, 32'h0, 4'h0, a0);
      do_txn(1'b0, 2'd2, 32'h14, 32'h0, 4'h0, a1);
      do_txn(1'b0, 2'd2, 32'h18, 32'h0, 4'h0, a2);
      e3 = a0 + LAT;
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      repeat (40) step();
      late = 0;
      foreach (pl_cyc[i]) if (pl_cyc[i] >= e3) late++;
      check_eq("t6_no_pulse_after_reset", late, 0);
      @(negedge clock);
      check_eq("t6_error_cleared", bus_main.protocol_error, 0);
      step();
      do_txn(1'b0, 2'd2, 32'h10, 32'h0, 4'h0, a0);
      repeat (6) step();
      expect_pulse("t6_latency", a0 + LAT, 32'hDEAD_BEEF);

      // LATENCY=8 instance: request held high against a 4-entry FIFO.
      reset_l8 = 1'b0;
      bus_l8.request = 1'b1;
      step();
      rdy_mask = '0;
      dr_mask  = '0;
      for (int k = 0; k < 21; k++) begin
         @(negedge clock);
         rdy_mask[k] = bus_l8.address_ready;
         dr_mask[k]  = bus_l8.data_ready;
         if (bus_l8.data_ready === 1'b1) check_eq("t4_store_data", bus_l8.read_data, 0);
         step();
         bus_l8.address = 32'((k + 1) * 4);
         if (k == 9) bus_l8.request = 1'b0;
      end
      check_eq("t4_ready_pattern", 32'(rdy_mask), 32'h1F_FE0F);
      check_eq("t4_pulse_pattern", 32'(dr_mask), 32'h4_1E00);
      check_eq("t4_error", bus_l8.protocol_error, 0);

      // Randomized traffic with occasional resets; the model checks every cycle.
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         bus_main.request = ($urandom_range(0, 3) != 0);
         bus_main.write   = $urandom_range(0, 1);
         case ($urandom_range(0, 7))
            0, 1, 2: sz = 2'd0;
            3, 4:    sz = 2'd1;
            5, 6:    sz = 2'd2;
            default: sz = 2'd3;
         endcase
         addr = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
         if ($urandom_range(0, 4) != 0) begin
            if (sz == 2'd1) addr[0] = 1'b0;
            if (sz == 2'd2) addr[1:0] = 2'b00;
         end
         lanes = (sz == 2'd0) ? (4'b0001 << addr[1:0]) :
                 (sz == 2'd1) ? (4'b0011 << addr[1:0]) : 4'b1111;
         bus_main.size         = sz;
         bus_main.address      = addr;
         bus_main.write_data   = $urandom;
         bus_main.write_strobe = ($urandom_range(0, 6) != 0) ? lanes : 4'($urandom);
         step();
      end
      reset = 1'b0;
      bus_main.request = 1'b0;
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
